// File: rtl/f1_start_sequencer.sv
// rtl/f1_start_sequencer.sv - F1 start-light sequencer with reaction timer
//
// Purpose:
//   Lights N_LIGHTS lamps one per LIGHT_PERIOD ticks. Once all lamps are lit it holds
//   for MIN_HOLD + rand_delay ticks and then extinguishes them. From that point it times
//   the driver's button press in ticks. A press while the lamps are lit or holding is
//   reported as a jump start. The reaction counter saturates at its maximum value.
//
// Ports:
//   sysclk        in   1         system clock
//   rst_n         in   1         asynchronous active-low reset
//   tick          in   1         1-cycle timebase pulse
//   trigger       in   1         start/clear request (synchronised level)
//   reaction      in   1         driver button (synchronised level, rising edge used)
//   rand_delay    in   DELAY_W   random hold extension from LFSR
//   en_lfsr       out  1         LFSR run enable (high while idle)
//   lights        out  N_LIGHTS  lamp drive, MSB lit first
//   busy          out  1         sequence in progress
//   reaction_ms   out  TIME_W    last reaction time in ticks
//   result_valid  out  1         reaction_ms holds a fresh result
//   jump_start    out  1         jump start detected
//   best_ms       out  TIME_W    best reaction time seen since reset
//
// Build option:
//   F1_BEST_TIME_EN  when defined, best_ms tracks the smallest reaction time since reset;
//                    otherwise best_ms is constant all ones.

module f1_start_sequencer #(
  parameter int N_LIGHTS     = 10,
  parameter int LIGHT_PERIOD = 500,
  parameter int DELAY_W      = 14,
  parameter int MIN_HOLD     = 200,
  parameter int TIME_W       = 14
) (
  input  logic                sysclk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                trigger,
  input  logic                reaction,
  input  logic [DELAY_W-1:0]  rand_delay,
  output logic                en_lfsr,
  output logic [N_LIGHTS-1:0] lights,
  output logic                busy,
  output logic [TIME_W-1:0]   reaction_ms,
  output logic                result_valid,
  output logic                jump_start,
  output logic [TIME_W-1:0]   best_ms
);

  localparam int LAMP_W = $clog2(N_LIGHTS + 1);
  localparam int TICK_W = $clog2(LIGHT_PERIOD + 1);
  localparam int HOLD_W = DELAY_W + 1;

  // Lamps fill from the MSB downwards, so each new lamp is a shift-in at the top.
  localparam logic [N_LIGHTS-1:0] TOP_LAMP = N_LIGHTS'(1) << (N_LIGHTS - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LIGHT_ON = 3'd1,
    ST_HOLD     = 3'd2,
    ST_MEASURE  = 3'd3,
    ST_RESULT   = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                reaction_q;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic [LAMP_W-1:0]   lamp_cnt_q, lamp_cnt_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TIME_W-1:0]   meas_q, meas_d;

  logic                en_lfsr_q, en_lfsr_d;
  logic [N_LIGHTS-1:0] lights_q, lights_d;
  logic                busy_q, busy_d;
  logic [TIME_W-1:0]   reaction_ms_q, reaction_ms_d;
  logic                result_valid_q, result_valid_d;
  logic                jump_start_q, jump_start_d;

  logic rise;
  logic period_done;
  logic last_lamp;
  logic hold_done;
  logic meas_sat;

  assign rise        = reaction & ~reaction_q;
  assign period_done = tick && (tick_cnt_q == TICK_W'(LIGHT_PERIOD - 1));
  assign last_lamp   = (lamp_cnt_q == LAMP_W'(N_LIGHTS - 1));
  // A zero hold ends on the first HOLD cycle without waiting for a tick.
  assign hold_done   = (hold_q == '0) || (tick && (hold_q == HOLD_W'(1)));
  assign meas_sat    = (meas_q == {TIME_W{1'b1}});

  // State and datapath registers
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      reaction_q     <= 1'b0;
      delay_q        <= '0;
      lamp_cnt_q     <= '0;
      tick_cnt_q     <= '0;
      hold_q         <= '0;
      meas_q         <= '0;
      en_lfsr_q      <= 1'b1;
      lights_q       <= '0;
      busy_q         <= 1'b0;
      reaction_ms_q  <= '0;
      result_valid_q <= 1'b0;
      jump_start_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      reaction_q     <= reaction;
      delay_q        <= delay_d;
      lamp_cnt_q     <= lamp_cnt_d;
      tick_cnt_q     <= tick_cnt_d;
      hold_q         <= hold_d;
      meas_q         <= meas_d;
      en_lfsr_q      <= en_lfsr_d;
      lights_q       <= lights_d;
      busy_q         <= busy_d;
      reaction_ms_q  <= reaction_ms_d;
      result_valid_q <= result_valid_d;
      jump_start_q   <= jump_start_d;
    end
  end

  // Next-state logic; a button rise always beats the final HOLD tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger) state_d = ST_LIGHT_ON;
      end
      ST_LIGHT_ON: begin
        if (rise)                          state_d = ST_FAULT;
        else if (period_done && last_lamp) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (rise)           state_d = ST_FAULT;
        else if (hold_done) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (rise) state_d = ST_RESULT;
      end
      ST_RESULT, ST_FAULT: begin
        if (trigger) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    delay_d        = delay_q;
    lamp_cnt_d     = lamp_cnt_q;
    tick_cnt_d     = tick_cnt_q;
    hold_d         = hold_q;
    meas_d         = meas_q;
    en_lfsr_d      = en_lfsr_q;
    lights_d       = lights_q;
    busy_d         = busy_q;
    reaction_ms_d  = reaction_ms_q;
    result_valid_d = result_valid_q;
    jump_start_d   = jump_start_q;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          delay_d    = rand_delay;
          lamp_cnt_d = '0;
          tick_cnt_d = '0;
          en_lfsr_d  = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_LIGHT_ON: begin
        if (rise) begin
          lights_d     = '1;
          jump_start_d = 1'b1;
          busy_d       = 1'b0;
        end else if (period_done) begin
          tick_cnt_d = '0;
          lamp_cnt_d = lamp_cnt_q + LAMP_W'(1);
          lights_d   = (lights_q >> 1) | TOP_LAMP;
          if (last_lamp) begin
            // Widened by one bit so MIN_HOLD plus the largest delay cannot wrap.
            hold_d = HOLD_W'(MIN_HOLD) + {1'b0, delay_q};
          end
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end
      ST_HOLD: begin
        if (rise) begin
          lights_d     = '1;
          jump_start_d = 1'b1;
          busy_d       = 1'b0;
        end else if (hold_done) begin
          lights_d = '0;
          meas_d   = '0;
        end else if (tick) begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          // Captures the count before this edge; a coincident tick is not added.
          reaction_ms_d  = meas_q;
          result_valid_d = 1'b1;
          busy_d         = 1'b0;
        end else if (tick && !meas_sat) begin
          meas_d = meas_q + TIME_W'(1);
        end
      end
      ST_RESULT, ST_FAULT: begin
        if (trigger) begin
          lights_d       = '0;
          jump_start_d   = 1'b0;
          result_valid_d = 1'b0;
          en_lfsr_d      = 1'b1;
        end
      end
      default: begin
        lights_d       = '0;
        busy_d         = 1'b0;
        en_lfsr_d      = 1'b1;
        jump_start_d   = 1'b0;
        result_valid_d = 1'b0;
      end
    endcase
  end

`ifdef F1_BEST_TIME_EN
  logic [TIME_W-1:0] best_q, best_d;

  always_comb begin
    best_d = best_q;
    if ((state_q == ST_MEASURE) && rise && (meas_q < best_q)) begin
      best_d = meas_q;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) best_q <= '1;
    else        best_q <= best_d;
  end

  assign best_ms = best_q;
`else
  assign best_ms = '1;
`endif

  assign en_lfsr      = en_lfsr_q;
  assign lights       = lights_q;
  assign busy         = busy_q;
  assign reaction_ms  = reaction_ms_q;
  assign result_valid = result_valid_q;
  assign jump_start   = jump_start_q;

endmodule
